pwm_led_multi: RTL and testbench

//  N-channel LED PWM driver; successor to the fixed 3-channel, 4-bit accumulator driver.
//  Per channel: WIDTH-bit duty register stepped by debounced up/down buttons or loaded directly.

---
 rtl/pwm_led_multi.sv | 181 ++++++++++++++++++
 tb/tb_pwm_led_multi.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_led_multi.sv
// Multi-channel LED PWM driver: debounced per-channel duty buttons, direct duty load,
// and runtime choice of sigma-delta or counter-compare modulation.
module pwm_led_multi #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int STEP     = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode_sel,
    input  logic [CHANNELS-1:0]       btn_up,
    input  logic [CHANNELS-1:0]       btn_dn,
    input  logic                      load,
    input  logic [2:0]                load_ch,
    input  logic [WIDTH-1:0]          load_val,
    output logic [CHANNELS*WIDTH-1:0] duty_out,
    output logic [CHANNELS-1:0]       led,
    output logic                      period_pls
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int NB = 2 * CHANNELS;
    localparam logic [WIDTH-1:0] DUTY_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]    TICK_ONE  = TW'(1);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] sum;
        sum = {1'b0, v} + STEP_W;
        if (sum[WIDTH]) begin
            sat_inc = DUTY_MAX;
        end else begin
            sat_inc = sum[WIDTH-1:0];
        end
    endfunction

    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        if ({1'b0, v} < STEP_W) begin
            sat_dec = '0;
        end else begin
            sat_dec = v - STEP_W[WIDTH-1:0];
        end
    endfunction

    logic [TW-1:0]    tick_q, tick_d;
    logic             tick_s;
    logic [NB-1:0]    btn_s, agree_s;
    logic [NB-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NB-1:0]    samp_q, samp_d, deb_q, deb_d, press_q, press_d;
    logic [WIDTH-1:0] duty_q [CHANNELS];
    logic [WIDTH-1:0] duty_d [CHANNELS];
    logic [WIDTH-1:0] act_q  [CHANNELS];
    logic [WIDTH-1:0] act_d  [CHANNELS];
    logic [WIDTH-1:0] acc_q  [CHANNELS];
    logic [WIDTH-1:0] acc_d  [CHANNELS];
    logic [WIDTH:0]   acc_sum_s [CHANNELS];
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             cnt_wrap_s;
    logic             started_q, started_d;
    logic             mode_q, mode_d, mode_chg_s;
    logic [CHANNELS-1:0] led_q, led_d;
    logic             pls_q, pls_d;

    // Next-state logic: tick divider, debouncers, duty registers, period counter, modulators.
    always_comb begin
        tick_s = (tick_q == TICK_LAST);
        if (tick_s) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TICK_ONE;
        end

        btn_s   = {btn_dn, btn_up};
        sync1_d = btn_s;
        sync2_d = sync1_q;
        agree_s = ~(sync2_q ^ samp_q);
        if (tick_s) begin
            samp_d  = sync2_q;
            deb_d   = (agree_s & sync2_q) | (~agree_s & deb_q);
            press_d = deb_d & ~deb_q;
        end else begin
            samp_d  = samp_q;
            deb_d   = deb_q;
            press_d = '0;
        end

        mode_d     = mode_sel;
        mode_chg_s = mode_sel ^ mode_q;
        started_d  = 1'b1;
        // The counter holds at 0 for the first cycle after reset so period_pls marks it.
        if (mode_chg_s) begin
            cnt_d = '0;
        end else if (started_q) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        pls_d      = (cnt_d == '0);
        cnt_wrap_s = (cnt_q == DUTY_MAX);

        for (int i = 0; i < CHANNELS; i++) begin
            if (cnt_wrap_s) begin
                act_d[i] = duty_q[i];
            end else begin
                act_d[i] = act_q[i];
            end

            if (load && (load_ch == 3'(i))) begin
                duty_d[i] = load_val;
            end else if (press_q[i] && !press_q[CHANNELS + i]) begin
                duty_d[i] = sat_inc(duty_q[i]);
            end else if (!press_q[i] && press_q[CHANNELS + i]) begin
                duty_d[i] = sat_dec(duty_q[i]);
            end else begin
                duty_d[i] = duty_q[i];
            end

            acc_sum_s[i] = {1'b0, acc_q[i]} + {1'b0, act_q[i]};
            if (mode_chg_s) begin
                acc_d[i] = '0;
                led_d[i] = 1'b0;
            end else if (mode_q) begin
                acc_d[i] = acc_sum_s[i][WIDTH-1:0];
                led_d[i] = (cnt_q < act_q[i]);
            end else begin
                acc_d[i] = acc_sum_s[i][WIDTH-1:0];
                led_d[i] = acc_sum_s[i][WIDTH];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            samp_q    <= '0;
            deb_q     <= '0;
            press_q   <= '0;
            cnt_q     <= '0;
            started_q <= 1'b0;
            mode_q    <= 1'b0;
            led_q     <= '0;
            pls_q     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i] <= '0;
                act_q[i]  <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            tick_q    <= tick_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            samp_q    <= samp_d;
            deb_q     <= deb_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
            started_q <= started_d;
            mode_q    <= mode_d;
            led_q     <= led_d;
            pls_q     <= pls_d;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i] <= duty_d[i];
                act_q[i]  <= act_d[i];
                acc_q[i]  <= acc_d[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_duty_out
        assign duty_out[g*WIDTH +: WIDTH] = duty_q[g];
    end

    assign led        = led_q;
    assign period_pls = pls_q;

endmodule

// File: tb/tb_pwm_led_multi.sv
// Self-checking bench for pwm_led_multi (3 channels, 4-bit duty, step 4, tick every 4 clocks).
module tb_pwm_led_multi;

    localparam int CH   = 3;
    localparam int W    = 4;
    localparam int STP  = 4;
    localparam int TDIV = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              mode_sel;
    logic [CH-1:0]     btn_up;
    logic [CH-1:0]     btn_dn;
    logic              load;
    logic [2:0]        load_ch;
    logic [W-1:0]      load_val;
    logic [CH*W-1:0]   duty_out;
    logic [CH-1:0]     led;
    logic              period_pls;

    int checks = 0;
    int errors = 0;

    pwm_led_multi #(.CHANNELS(CH), .WIDTH(W), .STEP(STP), .TICK_DIV(TDIV)) dut (
        .clk(clk), .reset(reset), .mode_sel(mode_sel), .btn_up(btn_up), .btn_dn(btn_dn),
        .load(load), .load_ch(load_ch), .load_val(load_val),
        .duty_out(duty_out), .led(led), .period_pls(period_pls)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        int          val;
        logic [11:0] exp_duty;
    } vec_t;
    vec_t tbl [10];

    // Reference model state: plain integers, sigma-delta tracked as a running total.
    int m_duty [CH];
    int m_act  [CH];
    int m_tot  [CH];
    bit m_led  [CH];
    int m_cnt;
    bit m_pls, m_started, m_mode;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_pls(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (period_pls) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, int'(seen), 1);
    endtask

    task automatic do_load(input int ch, input int val);
        load     = 1'b1;
        load_ch  = 3'(ch);
        load_val = 4'(val);
        step();
        load     = 1'b0;
    endtask

    task automatic press(input int ch, input bit up, input bit dn);
        btn_up[ch] = up;
        btn_dn[ch] = dn;
        steps(24);
        btn_up[ch] = 1'b0;
        btn_dn[ch] = 1'b0;
        steps(24);
    endtask

    function automatic int duty_of(input int ch);
        return int'(duty_out[ch*W +: W]);
    endfunction

    task automatic model_step();
        int nd [CH];
        bit chg;
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                m_duty[i] = 0; m_act[i] = 0; m_tot[i] = 0; m_led[i] = 1'b0;
            end
            m_cnt = 0; m_pls = 1'b0; m_started = 1'b0; m_mode = 1'b0;
        end else begin
            chg = (mode_sel != m_mode);
            for (int i = 0; i < CH; i++) begin
                nd[i] = m_duty[i];
                if (load && int'(load_ch) == i) nd[i] = int'(load_val);
                if (chg) begin
                    m_led[i] = 1'b0;
                    m_tot[i] = 0;
                end else if (m_mode) begin
                    m_led[i] = (m_cnt < m_act[i]);
                end else begin
                    m_led[i] = ((m_tot[i] + m_act[i]) / 16) != (m_tot[i] / 16);
                    m_tot[i] = m_tot[i] + m_act[i];
                end
            end
            if (m_cnt == 15) begin
                for (int i = 0; i < CH; i++) m_act[i] = m_duty[i];
            end
            for (int i = 0; i < CH; i++) m_duty[i] = nd[i];
            if (chg) m_cnt = 0;
            else if (m_started) m_cnt = (m_cnt + 1) % 16;
            m_started = 1'b1;
            m_mode    = mode_sel;
            m_pls     = (m_cnt == 0);
        end
    endtask

    initial begin
        int c0, c1, cx, cp, bad;
        logic [11:0] ed;
        logic [2:0]  el;

        tbl[0] = '{0, 9,  12'h009};
        tbl[1] = '{1, 3,  12'h039};
        tbl[2] = '{2, 15, 12'hF39};
        tbl[3] = '{5, 7,  12'hF39};
        tbl[4] = '{7, 1,  12'hF39};
        tbl[5] = '{0, 0,  12'hF30};
        tbl[6] = '{1, 15, 12'hFF0};
        tbl[7] = '{3, 2,  12'hFF0};
        tbl[8] = '{2, 0,  12'h0F0};
        tbl[9] = '{1, 0,  12'h000};

        reset = 1'b1; mode_sel = 1'b0; load = 1'b0; load_ch = 3'd0; load_val = 4'd0;
        btn_up = '0; btn_dn = '0;
        steps(3);
        check("rst_hold_pls", int'(period_pls), 0);
        reset = 1'b0;
        step();
        check("rst_rel_pls", int'(period_pls), 1);
        check("rst_rel_led", int'(led), 0);
        check("rst_rel_duty", int'(duty_out), 0);

        // Direct loads including out-of-range channels.
        for (int v = 0; v < 10; v++) begin
            do_load(tbl[v].ch, tbl[v].val);
            check($sformatf("tbl_load_%0d", v), int'(duty_out), int'(tbl[v].exp_duty));
        end

        // Compare mode: duty 5 on ch1.
        mode_sel = 1'b1;
        do_load(1, 5);
        check("cmp_chg_led", int'(led), 0);
        check("cmp_chg_pls", int'(period_pls), 1);
        check("cmp_duty", int'(duty_out), 12'h050);
        step();
        wait_pls("cmp_sync");
        c1 = 0; cx = 0; cp = 0; bad = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            c1 += int'(led[1]);
            cx += int'(led[0] | led[2]);
            cp += int'(period_pls);
            if (led[1] != (k <= 5)) bad++;
        end
        check("cmp_high5", c1, 5);
        check("cmp_shape", bad, 0);
        check("cmp_others0", cx, 0);
        check("cmp_pls_cnt", cp, 1);
        check("cmp_pls_end", int'(period_pls), 1);

        // Sigma-delta: duty 4 on ch0, then 15.
        mode_sel = 1'b0;
        do_load(0, 4);
        step();
        wait_pls("sd_sync");
        c0 = 0; c1 = 0; bad = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            c0 += int'(led[0]);
            c1 += int'(led[1]);
            if (led[0] != ((k % 4) == 0)) bad++;
        end
        check("sd_even", bad, 0);
        check("sd_cnt4", c0, 4);
        check("sd_ch1_5", c1, 5);
        do_load(0, 15);
        step();
        wait_pls("sd15_sync");
        c0 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            c0 += int'(led[0]);
        end
        check("sd_cnt15", c0, 15);

        // New duty only from the next period start.
        mode_sel = 1'b1;
        step();
        steps(7);
        do_load(0, 10);
        check("glitch_duty", duty_of(0), 10);
        c0 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            c0 += int'(led[0]);
        end
        check("glitch_old_rest", c0, 7);
        check("glitch_wrap_pls", int'(period_pls), 1);
        c0 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            c0 += int'(led[0]);
        end
        check("glitch_new10", c0, 10);

        // Load wins over a simultaneous button press; invalid channel is ignored.
        btn_up[0] = 1'b1; load = 1'b1; load_ch = 3'd0; load_val = 4'd6;
        steps(30);
        load = 1'b0;
        steps(20);
        check("prio_load", duty_of(0), 6);
        btn_up[0] = 1'b0;
        steps(30);
        check("prio_after", duty_of(0), 6);
        do_load(5, 3);
        check("ch5_ignored", int'(duty_out), 12'h056);

        // Mode switch mid-period.
        do_load(0, 12);
        wait_pls("msw_sync");
        steps(9);
        check("msw_pre_led", int'(led[0]), 1);
        mode_sel = 1'b0;
        step();
        check("msw_led0", int'(led), 0);
        check("msw_pls", int'(period_pls), 1);
        check("msw_duty", int'(duty_out), 12'h05C);
        step();
        check("msw_next_pls", int'(period_pls), 0);

        // Buttons: bounce, saturation, decrement, simultaneous.
        btn_up[2] = 1'b1; step();
        btn_up[2] = 1'b0; step();
        btn_up[2] = 1'b1; step();
        steps(27);
        check("btn_bounce", duty_of(2), 4);
        btn_up[2] = 1'b0;
        steps(24);
        check("btn_release", duty_of(2), 4);
        do_load(2, 12);
        press(2, 1'b1, 1'b0);
        check("btn_sat1", duty_of(2), 15);
        repeat (4) press(2, 1'b1, 1'b0);
        check("btn_sat5", duty_of(2), 15);
        do_load(2, 9);
        press(2, 1'b0, 1'b1);
        check("btn_dn9", duty_of(2), 5);
        do_load(2, 3);
        press(2, 1'b0, 1'b1);
        check("btn_dn_sat", duty_of(2), 0);
        do_load(2, 8);
        press(2, 1'b1, 1'b1);
        check("btn_both", duty_of(2), 8);

        // Reset mid-run.
        do_load(0, 9);
        steps(5);
        reset = 1'b1;
        steps(3);
        check("rst_mid_led", int'(led), 0);
        check("rst_mid_duty", int'(duty_out), 0);
        check("rst_mid_pls", int'(period_pls), 0);
        reset = 1'b0;
        step();
        check("rst_mid_rel_pls", int'(period_pls), 1);
        bad = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (period_pls) bad++;
        end
        check("rst_mid_no_pls", bad, 0);
        step();
        check("rst_mid_pls16", int'(period_pls), 1);

        // Randomized run against the reference model.
        for (int i = 0; i < 800; i++) begin
            reset    = (i < 2) || ($urandom_range(0, 299) == 0);
            load     = ($urandom_range(0, 3) == 0);
            load_ch  = 3'($urandom_range(0, 7));
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) mode_sel = ~mode_sel;
            model_step();
            step();
            for (int c = 0; c < CH; c++) begin
                ed[c*W +: W] = 4'(m_duty[c]);
                el[c]        = m_led[c];
            end
            check("rnd_duty", int'(duty_out), int'(ed));
            check("rnd_led", int'(led), int'(el));
            check("rnd_pls", int'(period_pls), int'(m_pls));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
